seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-pattern detector. It is the next generation of the fixed-pattern `fsm_mealy` detector. It matches a runtime-loadable PAT_W-bit pattern on a qualified serial stream. Output mode (Mealy or Moore) and overlap behaviour are selectable, and a saturating match counter is included. It sits between a serial front end (UART/button/shift sampler) and control logic that reacts to framing or command sequences.

## Interface
- PAT_W, 4, pattern length in bits (2..16)
- PATTERN, 4'b1011, pattern loaded at reset; bit [PAT_W-1] is the first bit received, bit [0] the last
- CNT_W, 8, match counter width (≥1)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_overlap/cfg_moore, clear history, fill, counter
- cfg_pattern  in  PAT_W  new pattern, same bit order as PATTERN
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history restarts after a match
- cfg_moore  in  1  1 = registered (Moore) output, 0 = combinational (Mealy) output
- in_valid  in  1  qualifies in_bit; bits with in_valid=0 are ignored entirely
- in_bit  in  1  serial data bit
- out_bit  out  1  match pulse, one cycle per match
- match_cnt  out  CNT_W  number of matches since reset/cfg_load, saturating
- cnt_sat  out  1  high while match_cnt == 2^CNT_W-1

## Operation
- Registers:
  - pat_r (reset PATTERN)
  - overlap_r (reset 1)
  - moore_r (reset 0)
  - hist[PAT_W-1:0] (reset 0; newest bit in LSB)
  - fill (0..PAT_W, reset 0)
  - match_cnt (reset 0)
  - moore_q (reset 0)
- Fill state machine:
  - States: FILLING (fill < PAT_W) and ARMED (fill == PAT_W).
  - FILLING→ARMED when the PAT_W-th valid bit is accepted.
  - ARMED→FILLING (fill=0) on a hit when overlap_r=0.
  - ARMED stays ARMED on a hit when overlap_r=1, and on a non-hit.
- Accepted bit (in_valid=1, cfg_load=0):
  - nxt_hist = {hist[PAT_W-2:0], in_bit}
  - nxt_fill = min(fill+1, PAT_W)
- hit = in_valid & ~cfg_load & (nxt_fill == PAT_W) & (nxt_hist == pat_r)
- On a hit:
  - match_cnt increments unless saturated; it holds at 2^CNT_W-1.
  - If overlap_r=0, fill is set to 0. hist is still updated, but the old bits cannot form a match until PAT_W new bits arrive.
- out_bit:
  - moore_r=0: out_bit = hit (combinational).
  - moore_r=1: out_bit = moore_q, where moore_q <= hit each edge.
  - Forced 0 while rst is high.
- cfg_load:
  - Has priority over in_valid. The bit in that cycle is discarded, out_bit=0, and no count.
  - Next edge: pat_r/overlap_r/moore_r take the cfg_* values; hist, fill, match_cnt and moore_q are cleared.
- Changing cfg_* without cfg_load has no effect.
- cnt_sat = &match_cnt (combinational from the register).

## Timing
- Reset: while rst=1, all registers take their reset values asynchronously and out_bit=0 with no clock. After release, the first rising edge can accept a bit.
- Mealy latency: out_bit rises in the same cycle as the completing valid bit, before the capturing edge. match_cnt updates at that edge.
- Moore latency: out_bit is high for the one cycle after the edge that accepted the completing bit. match_cnt updates at that same edge.
- Back-to-back matches with overlap (pattern with self-overlap, e.g. 1111): out_bit stays high on consecutive valid bits, one count per bit.
- in_valid gaps: hist/fill/moore_q hold except that moore_q returns to 0 after one cycle. A pattern split by gaps still matches.
- Reset mid-stream: partial history is lost, and a full PAT_W new valid bits are required before any match.
- Mode switch via cfg_load while moore_q=1: out_bit drops to 0 at that edge; no stale pulse.

## Test plan
- Reset defaults (1011, Mealy, overlap); valid stream 1,0,1,1,0,1,1 → out_bit high combinationally during bits 4 and 7 only; match_cnt=2 after the last edge.
- cfg_load with cfg_overlap=0, pattern 1011, same stream → single pulse on bit 4; match_cnt=1. With pattern 1111 and stream of six 1s → pulses on bits 4 only (overlap=0) vs bits 4,5,6 with match_cnt=3 (overlap=1).
- cfg_moore=1, pattern 1011, stream 1,0,1,1 → out_bit 0 during bit 4, high exactly the next cycle, then 0; match_cnt=1.
- Stream 1,0,1,1 with in_valid=0 idle cycles inserted between each bit (in_bit toggling randomly while invalid) → exactly one match; raising cfg_load together with the 4th valid bit → no match, match_cnt=0.
- CNT_W=2, overlap, pattern 1111, stream of eight 1s → match_cnt sequence 1,2,3,3,3; cnt_sat=1 from the third match on; out_bit still pulses on each match.
- Assert rst asynchronously between edges after 1,0,1 → out_bit/match_cnt go 0 immediately. After release, stream 1,0,1,1 → match only on the 4th post-reset bit.

Source files
------------

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Serial bit-pattern detector with a runtime-loadable PAT_W-bit pattern.
// A qualified serial stream is shifted into a history register. A match
// pulse is raised when the most recent PAT_W accepted bits equal the
// pattern. The output can be combinational (Mealy) or registered (Moore).
// Matches can be overlapping, or the history can restart after each match.
// A saturating counter tracks the number of matches.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   cfg_load     one-cycle strobe: latch cfg_*, clear history/fill/count
//   cfg_pattern  new pattern, bit [PAT_W-1] is the first bit received
//   cfg_overlap  1 = overlapping matches, 0 = restart after a match
//   cfg_moore    1 = registered output, 0 = combinational output
//   in_valid     qualifies in_bit
//   in_bit       serial data bit
//   out_bit      one-cycle match pulse
//   match_cnt    saturating match count since reset/cfg_load
//   cnt_sat      high while match_cnt is at its maximum value
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cfg_moore,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             out_bit,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [0:0] {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_t;

    // Saturating increment: holds at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (&val) begin
            res = val;
        end else begin
            res = val + CNT_W'(1);
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [PAT_W-1:0]  pat_r;
    logic              overlap_r;
    logic              moore_r;
    logic [PAT_W-1:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic [CNT_W-1:0]  match_cnt_r;
    logic              moore_q_r;

    logic              accept_s;
    logic [PAT_W-1:0]  shift_hist_s;
    logic [FILL_W-1:0] shift_fill_s;
    logic              hit_s;
    logic [PAT_W-1:0]  hist_nxt_s;
    logic [FILL_W-1:0] fill_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [PAT_W-1:0]  pat_nxt_s;
    logic              overlap_nxt_s;
    logic              moore_nxt_s;

    // Hit detection: candidate history and fill level for an accepted bit.
    always_comb begin
        accept_s     = in_valid & ~cfg_load;
        shift_hist_s = {hist_r[PAT_W-2:0], in_bit};
        // Once ARMED the fill level is saturated at PAT_W.
        if (state_r == ARMED) begin
            shift_fill_s = FILL_FULL;
        end else begin
            shift_fill_s = fill_r + FILL_W'(1);
        end
        hit_s = accept_s & (shift_fill_s == FILL_FULL) & (shift_hist_s == pat_r);
    end

    // Next-state logic for the fill FSM, history, counter and configuration.
    always_comb begin
        state_nxt_s   = state_r;
        hist_nxt_s    = hist_r;
        fill_nxt_s    = fill_r;
        cnt_nxt_s     = match_cnt_r;
        pat_nxt_s     = pat_r;
        overlap_nxt_s = overlap_r;
        moore_nxt_s   = moore_r;
        if (cfg_load) begin
            state_nxt_s   = FILLING;
            hist_nxt_s    = {PAT_W{1'b0}};
            fill_nxt_s    = {FILL_W{1'b0}};
            cnt_nxt_s     = {CNT_W{1'b0}};
            pat_nxt_s     = cfg_pattern;
            overlap_nxt_s = cfg_overlap;
            moore_nxt_s   = cfg_moore;
        end else if (accept_s) begin
            hist_nxt_s = shift_hist_s;
            case (state_r)
                FILLING, ARMED: begin
                    if (hit_s && !overlap_r) begin
                        // Non-overlapping: old bits may not contribute to the next match.
                        state_nxt_s = FILLING;
                        fill_nxt_s  = {FILL_W{1'b0}};
                    end else if (shift_fill_s == FILL_FULL) begin
                        state_nxt_s = ARMED;
                        fill_nxt_s  = FILL_FULL;
                    end else begin
                        state_nxt_s = FILLING;
                        fill_nxt_s  = shift_fill_s;
                    end
                end
                default: begin
                    state_nxt_s = FILLING;
                    fill_nxt_s  = {FILL_W{1'b0}};
                end
            endcase
            if (hit_s) begin
                cnt_nxt_s = sat_inc(match_cnt_r);
            end else begin
                cnt_nxt_s = match_cnt_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= FILLING;
            pat_r       <= PATTERN;
            overlap_r   <= 1'b1;
            moore_r     <= 1'b0;
            hist_r      <= {PAT_W{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            match_cnt_r <= {CNT_W{1'b0}};
            moore_q_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pat_r       <= pat_nxt_s;
            overlap_r   <= overlap_nxt_s;
            moore_r     <= moore_nxt_s;
            hist_r      <= hist_nxt_s;
            fill_r      <= fill_nxt_s;
            match_cnt_r <= cnt_nxt_s;
            // hit_s is already 0 during cfg_load, so this also clears on load.
            moore_q_r   <= hit_s;
        end
    end

    // Output logic: Mealy or Moore match pulse, count and saturation flag.
    always_comb begin
        if (rst) begin
            out_bit = 1'b0;
        end else if (moore_r) begin
            out_bit = moore_q_r;
        end else begin
            out_bit = hit_s;
        end
        match_cnt = match_cnt_r;
        cnt_sat   = &match_cnt_r;
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//
// Self-checking bench for seq_detector_param. Two instances share stimulus:
// one with an 8-bit counter and one with a 2-bit counter for saturation.
// The reference model keeps a queue of accepted bits since the last restart.
// It declares a match when the newest four bits equal the pattern.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic       cfg_moore;
    logic       in_valid;
    logic       in_bit;

    logic       out_bit;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic       out_bit2;
    logic [1:0] match_cnt2;
    logic       cnt_sat2;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int   q[$];
    logic [3:0] m_pat;
    bit   m_ov;
    bit   m_mo;
    bit   m_mq;
    int   cnt8;
    int   cnt2;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore), .in_valid(in_valid),
        .in_bit(in_bit), .out_bit(out_bit), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore), .in_valid(in_valid),
        .in_bit(in_bit), .out_bit(out_bit2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input bit v, input bit b, input bit ld);
        int t[$];
        int n;
        if (!v || ld) return 1'b0;
        t = q;
        t.push_back(int'(b));
        n = t.size();
        if (n < 4) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (t[n-4+i] != int'(m_pat[3-i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pat = 4'b1011;
        m_ov  = 1'b1;
        m_mo  = 1'b0;
        m_mq  = 1'b0;
        cnt8  = 0;
        cnt2  = 0;
    endtask

    // One clock cycle: drive, check out_bit before the edge, update model, check counts.
    task automatic step(input bit v, input bit b, input bit ld,
                        input logic [3:0] p, input bit ov, input bit mo);
        bit h;
        bit exp_out;
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        cfg_load = ld;
        if (ld) begin
            cfg_pattern = p;
            cfg_overlap = ov;
            cfg_moore   = mo;
        end else begin
            // configuration inputs without a load strobe must be ignored
            cfg_pattern = 4'($urandom_range(0, 15));
            cfg_overlap = 1'($urandom_range(0, 1));
            cfg_moore   = 1'($urandom_range(0, 1));
        end
        #1;
        h       = model_hit(v, b, ld);
        exp_out = m_mo ? m_mq : h;
        chk("out_bit", 32'(out_bit), 32'(exp_out));
        chk("out_bit_w2", 32'(out_bit2), 32'(exp_out));
        @(posedge clk);
        #1;
        if (ld) begin
            q.delete();
            m_pat = p;
            m_ov  = ov;
            m_mo  = mo;
            m_mq  = 1'b0;
            cnt8  = 0;
            cnt2  = 0;
        end else begin
            m_mq = h;
            if (v) begin
                q.push_back(int'(b));
                if (q.size() > 4) void'(q.pop_front());
                if (h) begin
                    cnt8 = (cnt8 < 255) ? cnt8 + 1 : 255;
                    cnt2 = (cnt2 < 3) ? cnt2 + 1 : 3;
                    if (!m_ov) q.delete();
                end
            end
        end
        chk("match_cnt", 32'(match_cnt), 32'(cnt8));
        chk("cnt_sat", 32'(cnt_sat), 32'(cnt8 == 255));
        chk("match_cnt_w2", 32'(match_cnt2), 32'(cnt2));
        chk("cnt_sat_w2", 32'(cnt_sat2), 32'(cnt2 == 3));
    endtask

    task automatic bitstep(input bit b);
        step(1'b1, b, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [3:0] p, input bit ov, input bit mo);
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1, p, ov, mo);
    endtask

    initial begin
        logic [6:0] s7;
        logic [3:0] pr;
        bit ld;
        s7 = 7'b1011011;

        // power-on reset: outputs low with no clock edge yet
        rst = 1'b1; cfg_load = 1'b0; cfg_pattern = 4'b0000; cfg_overlap = 1'b0;
        cfg_moore = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        model_reset();
        #2;
        chk("reset_out_bit", 32'(out_bit), 32'd0);
        chk("reset_match_cnt", 32'(match_cnt), 32'd0);
        chk("reset_cnt_sat", 32'(cnt_sat), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // defaults: 1011, Mealy, overlap -> hits on bits 4 and 7
        for (int i = 6; i >= 0; i--) bitstep(s7[i]);
        chk("tp1_cnt", 32'(match_cnt), 32'd2);

        // non-overlap 1011 -> single hit
        load(4'b1011, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) bitstep(s7[i]);
        chk("tp2_cnt", 32'(match_cnt), 32'd1);

        // 1111, six ones, non-overlap then overlap
        load(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) bitstep(1'b1);
        chk("tp2_1111_noov", 32'(match_cnt), 32'd1);
        load(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) bitstep(1'b1);
        chk("tp2_1111_ov", 32'(match_cnt), 32'd3);

        // Moore: pulse one cycle after the completing bit
        load(4'b1011, 1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) bitstep(s7[i]);
        idle();
        idle();
        chk("tp3_cnt", 32'(match_cnt), 32'd1);

        // mode switch to Mealy while moore_q is high
        for (int i = 2; i >= 0; i--) bitstep(s7[i]);
        load(4'b1011, 1'b1, 1'b0);
        idle();
        chk("tp3_switch_cnt", 32'(match_cnt), 32'd0);

        // gaps between bits still match
        for (int i = 3; i >= 0; i--) begin
            idle();
            idle();
            bitstep(s7[i]);
        end
        chk("tp4_gap_cnt", 32'(match_cnt), 32'd1);

        // cfg_load together with the completing bit discards it
        load(4'b1011, 1'b1, 1'b0);
        bitstep(1'b1); bitstep(1'b0); bitstep(1'b1);
        step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0);
        chk("tp4_load_cnt", 32'(match_cnt), 32'd0);

        // narrow counter saturation
        load(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) bitstep(1'b1);
        chk("tp5_cnt_w2", 32'(match_cnt2), 32'd3);
        chk("tp5_sat_w2", 32'(cnt_sat2), 32'd1);
        chk("tp5_cnt_w8", 32'(match_cnt), 32'd5);

        // asynchronous reset mid-stream, with a Mealy hit pending
        load(4'b1011, 1'b1, 1'b0);
        bitstep(1'b1); bitstep(1'b1); bitstep(1'b0); bitstep(1'b1); bitstep(1'b1);
        bitstep(1'b0); bitstep(1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        #1;
        chk("tp6_pre_rst_out", 32'(out_bit), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("tp6_rst_out", 32'(out_bit), 32'd0);
        chk("tp6_rst_cnt", 32'(match_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        bitstep(1'b1); bitstep(1'b0); bitstep(1'b1);
        chk("tp6_no_early", 32'(match_cnt), 32'd0);
        bitstep(1'b1);
        chk("tp6_post_cnt", 32'(match_cnt), 32'd1);

        // randomized stream against the queue model
        for (int n = 0; n < 400; n++) begin
            ld = ($urandom_range(0, 39) == 0);
            if (ld) begin
                case ($urandom_range(0, 3))
                    0:       pr = 4'b1111;
                    1:       pr = 4'b1010;
                    2:       pr = 4'b1011;
                    default: pr = 4'($urandom_range(0, 15));
                endcase
                load(pr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'b0, 4'b0000, 1'b0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
